// File: rtl/comparator_search.sv
// Successive-approximation search that recovers a comparator's hidden operand MSB-first.
// Optional macro SEARCH_TIMEOUT_EN aborts a probe that gets no response within TIMEOUT cycles.
module comparator_search #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    output logic                       start_ready_o,
    output logic [WIDTH-1:0]           probe_o,
    output logic                       probe_valid_o,
    input  logic                       resp_valid_i,
    input  logic                       resp_eq_i,
    input  logic                       resp_lt_i,
    output logic                       done_o,
    output logic [WIDTH-1:0]           result_o,
    output logic [$clog2(WIDTH+1)-1:0] probes_used_o,
    output logic                       err_o
);

    localparam int KW = $clog2(WIDTH);
    localparam int PW = $clog2(WIDTH+1);

    if (WIDTH < 2 || TIMEOUT < 1) begin : g_param_check
        $error("comparator_search: WIDTH must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, PROBE, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] probe_q, probe_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [KW-1:0]    k_q, k_d;
    logic [PW-1:0]    used_q, used_d;
    logic             err_q, err_d;
    logic             pv_q, pv_d;
    logic             finish;
    logic [WIDTH-1:0] newAcc;

`ifdef SEARCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT+1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = PROBE;
            PROBE:   if (finish)  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        start_ready_o = (state_q == IDLE);
        done_o        = (state_q == DONE);
    end

    // Datapath: a sampled response either finishes the search or issues the next probe on the same edge.
    always_comb begin
        acc_d    = acc_q;
        probe_d  = probe_q;
        result_d = result_q;
        k_d      = k_q;
        used_d   = used_q;
        err_d    = err_q;
        pv_d     = pv_q;
        finish   = 1'b0;
        newAcc   = acc_q;
`ifdef SEARCH_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    acc_d   = '0;
                    k_d     = KW'(WIDTH-1);
                    used_d  = '0;
                    err_d   = 1'b0;
                    probe_d = {1'b1, {(WIDTH-1){1'b0}}};
                    pv_d    = 1'b1;
`ifdef SEARCH_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            PROBE: begin
                if (pv_q && resp_valid_i) begin
                    used_d = used_q + PW'(1);
                    if (resp_eq_i) begin
                        err_d    = resp_lt_i;
                        result_d = probe_q;
                        finish   = 1'b1;
                    end else begin
                        newAcc = resp_lt_i ? probe_q : acc_q;
                        acc_d  = newAcc;
                        if (k_q == '0) begin
                            result_d = newAcc;
                            finish   = 1'b1;
                        end else begin
                            k_d     = k_q - KW'(1);
                            probe_d = newAcc | (WIDTH'(1) << (k_q - KW'(1)));
`ifdef SEARCH_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end
                    end
                end
`ifdef SEARCH_TIMEOUT_EN
                else if (pv_q) begin
                    if (cnt_q == CW'(TIMEOUT-1)) begin
                        err_d    = 1'b1;
                        result_d = acc_q;
                        finish   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
`endif
                if (finish) pv_d = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            probe_q  <= '0;
            result_q <= '0;
            k_q      <= '0;
            used_q   <= '0;
            err_q    <= 1'b0;
            pv_q     <= 1'b0;
`ifdef SEARCH_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            acc_q    <= acc_d;
            probe_q  <= probe_d;
            result_q <= result_d;
            k_q      <= k_d;
            used_q   <= used_d;
            err_q    <= err_d;
            pv_q     <= pv_d;
`ifdef SEARCH_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign probe_o       = probe_q;
    assign probe_valid_o = pv_q;
    assign result_o      = result_q;
    assign probes_used_o = used_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_comparator_search.sv
// Testbench for comparator_search: a comparator model with random response delay answers probes,
// and a scoreboard of expected {result, err, probes_used} is checked on every done pulse.
module tb_comparator_search;

    localparam int W  = 8;
    localparam int TO = 16;
    localparam int PW = $clog2(W+1);

    typedef struct {
        logic [W-1:0] target;
        int           injectAt;
        logic [W-1:0] expResult;
        logic         expErr;
        int           expUsed;
    } vec_t;

    typedef struct {
        logic [W-1:0] result;
        logic         err;
        int           used;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          resp_valid, resp_eq, resp_lt;
    logic          start_ready_o, probe_valid_o, done_o, err_o;
    logic [W-1:0]  probe_o, result_o;
    logic [PW-1:0] probes_used_o;

    exp_t         expQ[$];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;
    logic [W-1:0] target = '0;
    int           injectAt = 0;
    int           silentAfter = -1;
    int           maxDelay = 5;
    int           respNum = 0;
    int           waitCnt = -1;
    int           lastRespCyc = 0;
    int           doneCount = 0;
    int           doneCyc = 0;

    comparator_search #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .start_ready_o (start_ready_o),
        .probe_o       (probe_o),
        .probe_valid_o (probe_valid_o),
        .resp_valid_i  (resp_valid),
        .resp_eq_i     (resp_eq),
        .resp_lt_i     (resp_lt),
        .done_o        (done_o),
        .result_o      (result_o),
        .probes_used_o (probes_used_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Reference binary search: what an ideal comparator leads to for target t.
    function automatic void modelSearch(input logic [W-1:0] t, output logic [W-1:0] res, output int used);
        logic [W-1:0] acc = '0;
        logic [W-1:0] p;
        used = 0;
        res  = '0;
        for (int k = W-1; k >= 0; k--) begin
            p = acc | (W'(1) << k);
            used++;
            if (p == t) begin
                res = p;
                return;
            end
            if (p < t) acc = p;
        end
        res = acc;
    endfunction

    // Comparator model: answers each probe after 0..maxDelay cycles, optionally faulty or silent.
    initial begin
        resp_valid = 1'b0;
        resp_eq    = 1'b0;
        resp_lt    = 1'b0;
        forever begin
            @(negedge clk);
            resp_valid = 1'b0;
            if (rst || !probe_valid_o || (silentAfter >= 0 && respNum >= silentAfter)) begin
                waitCnt = -1;
            end else begin
                if (waitCnt < 0) waitCnt = int'($urandom_range(maxDelay, 0));
                if (waitCnt == 0) begin
                    respNum++;
                    resp_valid  = 1'b1;
                    resp_eq     = (probe_o == target);
                    resp_lt     = (probe_o < target);
                    if (respNum == injectAt) begin
                        resp_eq = 1'b1;
                        resp_lt = 1'b1;
                    end
                    lastRespCyc = cyc;
                    waitCnt     = -1;
                end else begin
                    waitCnt--;
                end
            end
        end
    end

    // Scoreboard consumer: every done pulse pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done_o) begin
                doneCount++;
                doneCyc = cyc;
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done: actual=1 expected=0");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("result", 32'(result_o), 32'(e.result));
                    checkOutput("err", 32'(err_o), 32'(e.err));
                    checkOutput("probes_used", 32'(probes_used_o), 32'(e.used));
                    checkOutput("done_probe_valid", 32'(probe_valid_o), 32'd0);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] t, input int inj, input int silent,
                                 input logic [W-1:0] expResult, input logic expErr, input int expUsed);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        while (!start_ready_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        target      = t;
        injectAt    = inj;
        silentAfter = silent;
        respNum     = 0;
        start       = 1'b1;
        @(posedge clk);
        e.result = expResult;
        e.err    = expErr;
        e.used   = expUsed;
        expQ.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (!(expQ.size() == 0 && start_ready_o) && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (n >= 600) begin
            checks++;
            errors++;
            $display("[TB] FAIL search_timeout: actual=%0d pending expected=0", expQ.size());
            expQ.delete();
        end
    endtask

    initial begin
        vec_t         vecs[7];
        logic [W-1:0] mRes;
        int           mUsed;
        int           d0;
        int           n;

        vecs[0] = '{target: 8'hA5, injectAt: 0, expResult: 8'hA5, expErr: 1'b0, expUsed: 8};
        vecs[1] = '{target: 8'h80, injectAt: 0, expResult: 8'h80, expErr: 1'b0, expUsed: 1};
        vecs[2] = '{target: 8'h00, injectAt: 0, expResult: 8'h00, expErr: 1'b0, expUsed: 8};
        vecs[3] = '{target: 8'hFF, injectAt: 0, expResult: 8'hFF, expErr: 1'b0, expUsed: 8};
        vecs[4] = '{target: 8'h3C, injectAt: 0, expResult: 8'h3C, expErr: 1'b0, expUsed: 6};
        vecs[5] = '{target: 8'h01, injectAt: 0, expResult: 8'h01, expErr: 1'b0, expUsed: 8};
        vecs[6] = '{target: 8'hA5, injectAt: 3, expResult: 8'hA0, expErr: 1'b1, expUsed: 3};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_start_ready", 32'(start_ready_o), 32'd1);
        checkOutput("rst_probe", 32'(probe_o), 32'd0);
        checkOutput("rst_probe_valid", 32'(probe_valid_o), 32'd0);
        checkOutput("rst_done", 32'(done_o), 32'd0);
        checkOutput("rst_result", 32'(result_o), 32'd0);
        checkOutput("rst_probes_used", 32'(probes_used_o), 32'd0);
        checkOutput("rst_err", 32'(err_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].target, vecs[i].injectAt, -1, vecs[i].expResult, vecs[i].expErr, vecs[i].expUsed);
            waitIdle();
        end

        $display("[TB] early-exit latency with zero-delay comparator");
        maxDelay = 0;
        applyStimulus(8'h80, 0, -1, 8'h80, 1'b0, 1);
        checkOutput("first_probe_valid", 32'(probe_valid_o), 32'd1);
        checkOutput("first_probe", 32'(probe_o), 32'h80);
        @(negedge clk);
        checkOutput("early_done_timing", 32'(done_o), 32'd1);
        waitIdle();
        maxDelay = 5;

        $display("[TB] illegal response with a start pulse while busy");
        d0 = doneCount;
        applyStimulus(8'hA5, 3, -1, 8'hA0, 1'b1, 3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitIdle();
        repeat (10) @(negedge clk);
        checkOutput("busy_start_done_count", 32'(doneCount - d0), 32'd1);
        checkOutput("busy_start_not_queued", 32'(probe_valid_o), 32'd0);

        $display("[TB] reset during probe 4");
        applyStimulus(8'h3C, 0, -1, 8'h3C, 1'b0, 6);
        n = 0;
        while (!(respNum >= 3 && probe_valid_o) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reached_probe4", 32'(respNum >= 3), 32'd1);
        d0  = doneCount;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrst_start_ready", 32'(start_ready_o), 32'd1);
        checkOutput("midrst_probe", 32'(probe_o), 32'd0);
        checkOutput("midrst_probe_valid", 32'(probe_valid_o), 32'd0);
        checkOutput("midrst_done", 32'(done_o), 32'd0);
        checkOutput("midrst_result", 32'(result_o), 32'd0);
        checkOutput("midrst_probes_used", 32'(probes_used_o), 32'd0);
        checkOutput("midrst_err", 32'(err_o), 32'd0);
        expQ.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midrst_no_done", 32'(doneCount - d0), 32'd0);
        applyStimulus(8'h3C, 0, -1, 8'h3C, 1'b0, 6);
        waitIdle();

`ifdef SEARCH_TIMEOUT_EN
        $display("[TB] silent comparator after two probes");
        applyStimulus(8'hA5, 0, 2, 8'h80, 1'b1, 2);
        waitIdle();
        checkOutput("timeout_latency", 32'(doneCyc - (lastRespCyc + 1)), 32'(TO));
        silentAfter = -1;
`endif

        $display("[TB] exhaustive targets");
        for (int t = 0; t < 256; t++) begin
            modelSearch(W'(t), mRes, mUsed);
            applyStimulus(W'(t), 0, -1, mRes, 1'b0, mUsed);
            waitIdle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
